// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: UART byte stream in, decoded command frame and error pulses out.
interface uart_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_payload;
    logic        err_csum;
    logic        err_format;
    logic        err_timeout;
    logic        err_overrun;
    logic [15:0] frame_count;
    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_code, cmd_len, cmd_payload,
        input  err_csum, err_format, err_timeout, err_overrun, frame_count
    );
    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_code, cmd_len, cmd_payload,
        output err_csum, err_format, err_timeout, err_overrun, frame_count
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC/CMD/LEN/payload/CSUM byte streams into a one-entry command register.
module uart_cmd_parser #(
    parameter int         CLK_FREQ   = 65_000_000,
    parameter int         TIMEOUT_US = 2000,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 4
) (
    input logic              clk,
    input logic              rst_n,
    uart_cmd_parser_if.slave bus
);
    localparam int TIMEOUT_CLKS = (CLK_FREQ / 1_000_000) * TIMEOUT_US;
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {S_SYNC, S_CMD, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    acc_q, acc_d, cmd_q, cmd_d, cmd_code_q, cmd_code_d;
    logic [2:0]    len_q, len_d, cmd_len_q, cmd_len_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d, cmd_payload_q, cmd_payload_d;
    logic [15:0]   frame_count_q, frame_count_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          err_csum_q, err_csum_d, err_format_q, err_format_d;
    logic          err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;

    logic rx_valid, tmo, len_bad, last, done, good, load;
    logic [7:0] rx_data;

    assign rx_valid = bus.rx_valid;
    assign rx_data  = bus.rx_data;
    // An arriving byte always beats the timeout on the same cycle.
    assign tmo      = state_q != S_SYNC && !rx_valid && cnt_q == CW'(TIMEOUT_CLKS - 1);
    assign len_bad  = rx_data > 8'(MAX_LEN);
    assign last     = {1'b0, idx_q} == len_q - 3'd1;
    assign done     = rx_valid && state_q == S_CSUM;
    assign good     = done && rx_data == acc_q;
    assign load     = good && (!cmd_valid_q || bus.cmd_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                S_SYNC:    state_d = rx_data == SYNC_BYTE ? S_CMD : S_SYNC;
                S_CMD:     state_d = S_LEN;
                S_LEN:     state_d = len_bad ? S_SYNC : rx_data == 8'd0 ? S_CSUM : S_PAYLOAD;
                S_PAYLOAD: state_d = last ? S_CSUM : S_PAYLOAD;
                default:   state_d = S_SYNC;
            endcase
        end else if (tmo) begin
            state_d = S_SYNC;
        end
    end

    always_comb begin
        cnt_d    = (rx_valid || tmo || state_q == S_SYNC) ? '0 : cnt_q + CW'(1);
        acc_d    = acc_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (rx_valid) begin
            case (state_q)
                S_CMD: begin
                    cmd_d = rx_data;
                    acc_d = rx_data;
                end
                S_LEN: if (!len_bad) begin
                    acc_d    = acc_q ^ rx_data;
                    len_d    = rx_data[2:0];
                    idx_d    = '0;
                    shadow_d = '0;
                end
                S_PAYLOAD: begin
                    shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
                    acc_d = acc_q ^ rx_data;
                    idx_d = idx_q + 2'd1;
                end
                default: ;
            endcase
        end
        cmd_valid_d   = load || (cmd_valid_q && !bus.cmd_ready);
        cmd_code_d    = load ? cmd_q : cmd_code_q;
        cmd_len_d     = load ? len_q : cmd_len_q;
        cmd_payload_d = load ? shadow_q : cmd_payload_q;
        frame_count_d = load ? frame_count_q + 16'd1 : frame_count_q;
        err_csum_d    = done && !good;
        err_format_d  = rx_valid && state_q == S_LEN && len_bad;
        err_timeout_d = tmo;
        err_overrun_d = good && !load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            cmd_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            frame_count_q <= '0;
            err_csum_q    <= 1'b0;
            err_format_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            frame_count_q <= frame_count_d;
            err_csum_q    <= err_csum_d;
            err_format_q  <= err_format_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_code    = cmd_code_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.cmd_payload = cmd_payload_q;
    assign bus.frame_count = frame_count_q;
    assign bus.err_csum    = err_csum_q;
    assign bus.err_format  = err_format_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frame scenarios followed by random frames checked against a frame-level model.
module tb_uart_cmd_parser;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus();
    uart_cmd_parser #(.CLK_FREQ(1_000_000), .TIMEOUT_US(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic errs(input string tag, input logic [3:0] exp);
        chk({tag, " errs"}, {28'd0, bus.err_csum, bus.err_format, bus.err_timeout, bus.err_overrun}, {28'd0, exp});
    endtask

    task automatic out(input string tag, input logic v, input logic [7:0] code, input logic [2:0] len,
                       input logic [31:0] pl, input logic [15:0] fc);
        chk({tag, " valid"}, {31'd0, bus.cmd_valid}, {31'd0, v});
        chk({tag, " count"}, {16'd0, bus.frame_count}, {16'd0, fc});
        if (v) begin
            chk({tag, " code"}, {24'd0, bus.cmd_code}, {24'd0, code});
            chk({tag, " len"}, {29'd0, bus.cmd_len}, {29'd0, len});
            chk({tag, " payload"}, bus.cmd_payload, pl);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_all(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        logic [15:0] exp_fc;
        logic [7:0] cmd, ln, cs, b, g;
        logic [31:0] pl;
        int kind;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b1;
        #12;
        out("reset", 1'b0, 8'h00, 3'd0, 32'h0, 16'd0);
        chk("reset code", {24'd0, bus.cmd_code}, 32'h0);
        chk("reset payload", bus.cmd_payload, 32'h0);
        errs("reset", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        send_all('{8'hA5, 8'h01, 8'h00, 8'h01});
        out("empty frame", 1'b1, 8'h01, 3'd0, 32'h0, 16'd1);
        errs("empty frame", 4'b0000);
        idle(1);
        chk("empty frame drop", {31'd0, bus.cmd_valid}, 32'd0);

        send_all('{8'h33, 8'hA5, 8'h02, 8'h02, 8'h10, 8'h20, 8'h30});
        out("two byte", 1'b1, 8'h02, 3'd2, 32'h0000_2010, 16'd2);
        errs("two byte", 4'b0000);
        idle(1);

        send_all('{8'hA5, 8'h02, 8'h02, 8'h10, 8'h20, 8'h31});
        errs("bad csum", 4'b1000);
        chk("bad csum valid", {31'd0, bus.cmd_valid}, 32'd0);
        idle(1);
        errs("bad csum after", 4'b0000);
        send_all('{8'hA5, 8'h03, 8'h05});
        errs("bad len", 4'b0100);
        idle(1);
        errs("bad len after", 4'b0000);
        send_all('{8'hA5, 8'h01, 8'h00, 8'h01});
        out("recover", 1'b1, 8'h01, 3'd0, 32'h0, 16'd3);
        idle(1);

        send_all('{8'hA5, 8'h01});
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            errs($sformatf("timeout gap %0d", k), k == 10 ? 4'b0010 : 4'b0000);
        end
        idle(1);
        errs("timeout after", 4'b0000);
        send_all('{8'hA5, 8'h01});
        for (int k = 1; k <= 9; k++) begin
            idle(1);
            errs($sformatf("late gap %0d", k), 4'b0000);
        end
        send(8'h00);
        errs("late byte", 4'b0000);
        send(8'h01);
        out("late frame", 1'b1, 8'h01, 3'd0, 32'h0, 16'd4);
        idle(1);

        bus.cmd_ready = 1'b0;
        send_all('{8'hA5, 8'h01, 8'h00, 8'h01});
        out("hold first", 1'b1, 8'h01, 3'd0, 32'h0, 16'd5);
        idle(2);
        out("hold stable", 1'b1, 8'h01, 3'd0, 32'h0, 16'd5);
        send_all('{8'hA5, 8'h02, 8'h01, 8'h55, 8'h56});
        errs("overrun", 4'b0001);
        out("overrun keep", 1'b1, 8'h01, 3'd0, 32'h0, 16'd5);
        idle(1);
        errs("overrun after", 4'b0000);
        send_all('{8'hA5, 8'h02, 8'h01, 8'h55});
        bus.cmd_ready = 1'b1;
        send(8'h56);
        out("replace", 1'b1, 8'h02, 3'd1, 32'h0000_0055, 16'd6);
        errs("replace", 4'b0000);
        idle(1);
        chk("replace drop", {31'd0, bus.cmd_valid}, 32'd0);

        send_all('{8'hA5, 8'h04, 8'h02, 8'hAA});
        rst_n = 1'b0;
        #1;
        out("mid reset", 1'b0, 8'h00, 3'd0, 32'h0, 16'd0);
        chk("mid reset code", {24'd0, bus.cmd_code}, 32'h0);
        chk("mid reset payload", bus.cmd_payload, 32'h0);
        errs("mid reset", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_all('{8'hA5, 8'h01, 8'h00, 8'h01});
        out("post reset", 1'b1, 8'h01, 3'd0, 32'h0, 16'd1);
        idle(1);

        exp_fc = 16'd1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            cmd  = 8'($urandom);
            q    = {};
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                q.push_back(g == 8'hA5 ? 8'h5A : g);
            end
            q.push_back(8'hA5);
            q.push_back(cmd);
            if (kind == 0) begin
                q.push_back(8'($urandom_range(5, 255)));
                send_all(q);
                errs($sformatf("rnd%0d format", i), 4'b0100);
            end else begin
                ln = 8'($urandom_range(0, 4));
                q.push_back(ln);
                cs = cmd ^ ln;
                pl = 32'h0;
                for (int j = 0; j < 32'(ln); j++) begin
                    b = 8'($urandom);
                    q.push_back(b);
                    cs ^= b;
                    pl |= 32'(b) << (8 * j);
                end
                if (kind == 1) cs ^= 8'(1 << $urandom_range(0, 7));
                q.push_back(cs);
                send_all(q);
                if (kind == 1) begin
                    errs($sformatf("rnd%0d csum", i), 4'b1000);
                    chk($sformatf("rnd%0d csum valid", i), {31'd0, bus.cmd_valid}, 32'd0);
                end else begin
                    exp_fc++;
                    errs($sformatf("rnd%0d good", i), 4'b0000);
                    out($sformatf("rnd%0d", i), 1'b1, cmd, ln[2:0], pl, exp_fc);
                end
            end
            idle($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Frame-level controller that sits directly after the UART byte receiver in the flappy_bird input path. It consumes the byte stream (data_out/data_valid) and runs a framing state machine: sync, command, length, payload, checksum. Good frames are presented to the game logic over a one-entry valid/ready interface. Malformed, corrupted, stalled or overrun frames are dropped and flagged.

Parameters:
CLK_FREQ, 65_000_000, system clock frequency in Hz.
TIMEOUT_US, 2000, maximum inter-byte gap inside a frame, in µs. TIMEOUT_CLKS = (CLK_FREQ/1_000_000)*TIMEOUT_US. The counter width is sized to hold TIMEOUT_CLKS.
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 4, maximum payload bytes (fixed at 4; payload bus is 32 bits).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
rx_data  in  8  byte from UART receiver.
rx_valid  in  1  one-cycle strobe, rx_data valid.
cmd_valid  out  1  completed frame available.
cmd_ready  in  1  consumer accepts frame when high with cmd_valid.
cmd_code  out  8  command byte.
cmd_len  out  3  payload length, 0..4.
cmd_payload  out  32  payload; byte i in bits [8i+7:8i]; unused bytes 0.
err_csum  out  1  one-cycle pulse on checksum mismatch.
err_format  out  1  one-cycle pulse on length > MAX_LEN.
err_timeout  out  1  one-cycle pulse on inter-byte timeout.
err_overrun  out  1  one-cycle pulse when a good frame is dropped because output is full.
frame_count  out  16  count of good frames delivered to output register, wraps at 16'hFFFF->0.

Behaviour:
- Reset (async, rst_n=0): state S_SYNC. All outputs 0. Timeout counter, checksum accumulator, byte index and payload shadow register cleared.
- Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CSUM. CSUM = CMD ^ LEN ^ payload bytes.
- State machine. States advance only on rx_valid cycles:
  - S_SYNC: byte == SYNC_BYTE -> S_CMD. Other bytes are ignored silently.
  - S_CMD: latch cmd, acc = byte -> S_LEN.
  - S_LEN: byte > MAX_LEN -> pulse err_format, S_SYNC. Byte == 0 -> S_CSUM. Else latch len, idx = 0, clear payload shadow -> S_PAYLOAD. acc ^= byte in all non-error cases.
  - S_PAYLOAD: store byte at shadow[idx], acc ^= byte. When idx == len-1 -> S_CSUM, else idx++.
  - S_CSUM: byte != acc -> pulse err_csum. Otherwise the frame completes. Always -> S_SYNC.
- Completion:
  - Output register is empty, or cmd_ready is high in the same cycle: load cmd_code/cmd_len/cmd_payload and assert cmd_valid on the next cycle (1-cycle latency after the CSUM strobe). frame_count increments.
  - cmd_valid is high and cmd_ready is low: frame discarded, err_overrun pulses, outputs unchanged, frame_count unchanged.
- Handshake: cmd_valid stays high with stable data until a cycle with cmd_valid && cmd_ready. cmd_valid drops the following cycle unless a new completion loads in that same cycle.
- Timeout:
  - The counter clears on every rx_valid and holds at 0 in S_SYNC.
  - It increments each cycle in any other state. On reaching TIMEOUT_CLKS-1 -> S_SYNC, err_timeout pulses, partial frame discarded.
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed normally and no timeout occurs.
- Error pulses are mutually exclusive per cycle and last exactly one cycle. The parser accepts back-to-back rx_valid on consecutive cycles.
- Reset mid-frame: immediate return to S_SYNC, pending output lost, cmd_valid = 0.

Test Plan:
- A5 01 00 01, cmd_ready=1 -> cmd_valid for 1 cycle, cmd_code=01, cmd_len=0, cmd_payload=0, frame_count=1, no error pulses.
- 33 A5 02 02 10 20 30 -> leading 33 ignored; cmd_code=02, cmd_len=2, cmd_payload=32'h0000_2010.
- A5 02 02 10 20 31 -> err_csum pulse, cmd_valid stays 0. A5 03 05 -> err_format pulse; a following valid frame A5 01 00 01 is still decoded correctly.
- Bench CLK_FREQ=1_000_000, TIMEOUT_US=10. Send A5 01, then idle -> err_timeout exactly 10 cycles after the last strobe. Repeat with a byte arriving on cycle 10 -> no timeout.
- cmd_ready=0; send two good frames -> first held stable, err_overrun on second, frame_count=1. Raise cmd_ready on the second frame's CSUM cycle -> second frame replaces the first, cmd_valid continuous, frame_count=2.
- Assert rst_n=0 after A5 04 02 AA -> all outputs 0. After release, A5 01 00 01 decodes normally.
